// File: rtl/mult_acc_pkg.sv
// Shared types and default widths for the product accumulator.
// Consumers: mult_acc_add, mult_accumulator.
package mult_acc_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int LEN_W_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_acc_add.sv
// Accumulator adder: acc + zero-extended product, with carry-out.
// Build option MULT_ACC_SATURATE_EN clamps the sum to all-ones on carry.
module mult_acc_add
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign carry = full[ACC_W];

`ifdef MULT_ACC_SATURATE_EN
  // Once clamped, any further non-zero product carries again and re-clamps.
  assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Burst accumulator for multiplier products with valid/ready result handshake.
// Optional saturation via MULT_ACC_SATURATE_EN (see mult_acc_add).
//
// state | meaning
// IDLE  | waiting for start; len sampled here
// ACCUM | accepting products, count down to the final transfer
// DONE  | result presented until out_ready
module mult_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  state_t           state;
  logic [LEN_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             xfer;

  mult_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc   (acc),
    .prod  (in_prod),
    .sum   (sum),
    .carry (carry)
  );

  assign xfer    = in_valid & in_ready;
  assign out_acc = acc;
  assign out_ovf = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b1;
            if (len != '0) begin
              count    <= len;
              in_ready <= 1'b1;
              state    <= ACCUM;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc   <= sum;
            ovf   <= ovf | carry;
            count <= count - 1'b1;
            // Terminal count: this transfer is the last of the burst.
            if (count == LEN_W'(1)) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed scoreboard bench for mult_accumulator (ACC_W=10 to reach overflow).
// Honours MULT_ACC_SATURATE_EN for the expected overflow result.
module tb_mult_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;
  logic              busy;

  typedef struct {
    int unsigned acc;
    logic        ovf;
  } exp_t;

  exp_t        sbq[$];
  int unsigned prods[$];
  int          checks = 0;
  int          failures = 0;

  mult_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference model: unsigned sum of prods, wrap or clamp at ACC_W bits.
  function automatic exp_t model();
    exp_t e;
    int unsigned s = 0;
    e.ovf = 1'b0;
    foreach (prods[i]) begin
      s = s + prods[i];
      if (s >= (1 << ACC_W)) begin
        e.ovf = 1'b1;
`ifdef MULT_ACC_SATURATE_EN
        s = (1 << ACC_W) - 1;
`else
        s = s - (1 << ACC_W);
`endif
      end
    end
    e.acc = s;
    return e;
  endfunction

  task automatic start_burst(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, (l != 0) ? 1 : 0);
  endtask

  task automatic send(input int unsigned p, input string tag);
    int n = 0;
    in_valid = 1'b1;
    in_prod  = PROD_W'(p);
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk({tag, "_ready_timeout"}, 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  // Sends all queued products, checks out_valid timing, pushes expected result.
  task automatic feed(input int gap, input string tag);
    exp_t e;
    e = model();
    foreach (prods[i]) begin
      if (i != 0) repeat (gap) begin
        step();
        chk({tag, "_ready_in_gap"}, in_ready, 1);
      end
      send(prods[i], tag);
      chk({tag, "_valid_latency"}, out_valid, (i == prods.size() - 1) ? 1 : 0);
    end
    sbq.push_back(e);
  endtask

  task automatic get_result(input int hold, input string tag);
    exp_t e;
    int   n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk({tag, "_valid_timeout"}, 0, 1);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_acc"}, out_acc, e.acc);
    chk({tag, "_ovf"}, out_ovf, e.ovf);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    repeat (hold) begin
      step();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_acc"}, out_acc, e.acc);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_busy_drop"}, busy, 0);
    chk({tag, "_acc_kept"}, out_acc, e.acc);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Basic burst, back-to-back.
    prods = '{225, 225, 225, 225};
    start_burst(4);
    feed(0, "basic");
    get_result(0, "basic");
    chk("basic_acc_900", out_acc, 900);

    // Input gaps and output backpressure.
    step();
    prods = '{6, 10, 14};
    start_burst(3);
    feed(2, "gaps");
    get_result(3, "gaps");
    chk("gaps_acc_30", out_acc, 30);

    // Overflow.
    step();
    prods = '{225, 225, 225, 225, 225};
    start_burst(5);
    feed(0, "ovf");
`ifdef MULT_ACC_SATURATE_EN
    chk("ovf_sat_acc", out_acc, 1023);
`else
    chk("ovf_wrap_acc", out_acc, 101);
`endif
    get_result(1, "ovf");

    // Zero length.
    step();
    prods = {};
    start_burst(0);
    chk("zero_valid_next", out_valid, 1);
    sbq.push_back(model());
    get_result(1, "zero");
    chk("zero_in_ready", in_ready, 0);

    // start while busy is ignored.
    step();
    prods = '{3, 4};
    start_burst(2);
    in_valid = 1'b1;
    in_prod  = 8'd3;
    start = 1'b1;
    len   = 5'd9;
    step();
    in_valid = 1'b0;
    start = 1'b0;
    step();
    chk("ign_still_accum", in_ready, 1);
    send(4, "ign");
    chk("ign_done_after_2", out_valid, 1);
    sbq.push_back(model());
    get_result(0, "ign");

    // Reset mid-burst, then a fresh single-product burst.
    step();
    prods = '{50, 60};
    start_burst(4);
    send(50, "rst");
    send(60, "rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc", out_acc, 0);
    chk("mid_rst_valid", out_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    prods = '{49};
    start_burst(1);
    feed(0, "post_rst");
    get_result(0, "post_rst");
    chk("post_rst_acc_49", out_acc, 49);
    chk("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
